i2c_temp_poller: RTL

I2C_TEMP_POLLER -- requirements
Module: i2c_temp_poller

---
 rtl/i2c_temp_poller_if.sv | 26 ++
 rtl/i2c_temp_poller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/i2c_temp_poller_if.sv
// Bus bundle for i2c_temp_poller: CSR slave port plus the master port toward the I2C peripheral.
interface i2c_temp_poller_if;
   logic [31:0] data_i;
   logic [31:0] addr_i;
   logic        we_i;
   logic        req_i;
   logic [31:0] data_o;
   logic        ready_o;
   logic        m_req_o;
   logic        m_we_o;
   logic [31:0] m_addr_o;
   logic [31:0] m_data_o;
   logic [31:0] m_data_i;
   logic        m_ready_i;
   logic        irq_o;

   modport slave (
      input  data_i, addr_i, we_i, req_i, m_data_i, m_ready_i,
      output data_o, ready_o, m_req_o, m_we_o, m_addr_o, m_data_o, irq_o
   );

   modport master (
      output data_i, addr_i, we_i, req_i, m_data_i, m_ready_i,
      input  data_o, ready_o, m_req_o, m_we_o, m_addr_o, m_data_o, irq_o
   );
endinterface

// File: rtl/i2c_temp_poller.sv
// Periodic / one-shot temperature poller: reads an I2C peripheral, queues 8-bit samples in a FIFO,
// raises sticky alarm/overflow/timeout flags and a level interrupt.
module i2c_temp_poller #(
   parameter int unsigned DEPTH      = 8,
   parameter logic [31:0] TIMEOUT    = 32'd1_000_000,
   parameter logic [31:0] PERIOD_RST = 32'd50_000_000
) (
   input logic              clk_i,
   input logic              rst_i,
   i2c_temp_poller_if.slave bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {IDLE, WAIT, ISSUE, BUSY} state_t;
   state_t r_state, w_next;

   logic          r_en;
   logic [31:0]   r_period;
   logic [15:0]   r_thresh;
   logic          r_ovf, r_alm_hi, r_alm_lo, r_tmo, r_irq;
   logic [31:0]   r_wait_cnt, r_tmo_cnt;
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;

   logic [3:0]    w_sel;
   logic          w_wr, w_rd, w_ctrl_wr, w_status_wr;
   logic          w_empty, w_full, w_pop, w_push;
   logic          w_req, w_capture, w_tmo_hit;
   logic [7:0]    w_sample;
   logic [31:0]   w_count32, w_rdata;
   logic [3:0]    w_count_sat;
   logic          w_unused;

   assign w_sel       = bus.addr_i[19:16];
   assign w_wr        = bus.req_i && bus.we_i;
   assign w_rd        = bus.req_i && !bus.we_i;
   assign w_ctrl_wr   = w_wr && (w_sel == 4'd0);
   assign w_status_wr = w_wr && (w_sel == 4'd3);
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == CW'(DEPTH));
   assign w_pop       = w_rd && (w_sel == 4'd4) && !w_empty;
   assign w_push      = w_capture && (!w_full || w_pop);
   assign w_sample    = bus.m_data_i[7:0];
   assign w_count32   = 32'(r_count);
   assign w_count_sat = (w_count32 > 32'd15) ? 4'hF : w_count32[3:0];
   assign w_unused    = ^{bus.addr_i[31:20], bus.addr_i[15:0], bus.m_data_i[31:8]};

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_ctrl_wr && (bus.data_i[0] || bus.data_i[1])) w_next = ISSUE;
         WAIT:    if (!r_en) w_next = IDLE;
                  else if (r_wait_cnt <= 32'd1) w_next = ISSUE;
         ISSUE:   if (w_tmo_hit) w_next = r_en ? WAIT : IDLE;
                  else if (!bus.m_ready_i) w_next = BUSY;
         BUSY:    if (w_capture || w_tmo_hit) w_next = r_en ? WAIT : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // A capture in the final timeout cycle wins: the sample is real, so no tmo.
   always_comb begin
      w_req     = 1'b0;
      w_capture = 1'b0;
      w_tmo_hit = 1'b0;
      if (r_state == ISSUE || r_state == BUSY) begin
         w_req     = 1'b1;
         w_tmo_hit = (r_tmo_cnt == TIMEOUT - 32'd1);
      end
      if (r_state == BUSY && bus.m_ready_i) begin
         w_capture = 1'b1;
         w_tmo_hit = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wait_cnt <= '0;
         r_tmo_cnt  <= '0;
      end else begin
         if (w_next == WAIT && r_state != WAIT)
            r_wait_cnt <= (r_period == '0) ? 32'd1 : r_period;
         else if (r_state == WAIT && r_wait_cnt != '0)
            r_wait_cnt <= r_wait_cnt - 32'd1;
         if (w_req && (w_next == ISSUE || w_next == BUSY)) r_tmo_cnt <= r_tmo_cnt + 32'd1;
         else                                              r_tmo_cnt <= '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_en     <= 1'b0;
         r_period <= PERIOD_RST;
         r_thresh <= 16'h7F80;
      end else if (w_wr) begin
         case (w_sel)
            4'd0:    r_en     <= bus.data_i[0];
            4'd1:    r_period <= bus.data_i;
            4'd2:    r_thresh <= bus.data_i[15:0];
            default: ;
         endcase
      end
   end

   // W1C is applied first, then any same-cycle set, so a set always survives.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ovf    <= 1'b0;
         r_alm_hi <= 1'b0;
         r_alm_lo <= 1'b0;
         r_tmo    <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_ovf    <= (r_ovf && !(w_status_wr && bus.data_i[6])) || (w_capture && !w_push);
         r_alm_hi <= (r_alm_hi && !(w_status_wr && bus.data_i[7]))
                     || (w_capture && ($signed(w_sample) > $signed(r_thresh[15:8])));
         r_alm_lo <= (r_alm_lo && !(w_status_wr && bus.data_i[8]))
                     || (w_capture && ($signed(w_sample) < $signed(r_thresh[7:0])));
         r_tmo    <= (r_tmo && !(w_status_wr && bus.data_i[9])) || w_tmo_hit;
         r_irq    <= r_ovf || r_alm_hi || r_alm_lo || r_tmo;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= w_sample;
   end

   always_comb begin
      w_rdata = '0;
      if (w_rd) begin
         case (w_sel)
            4'd1:    w_rdata = r_period;
            4'd2:    w_rdata = {16'h0, r_thresh};
            4'd3:    w_rdata = {22'h0, r_tmo, r_alm_lo, r_alm_hi, r_ovf, w_full, w_empty, w_count_sat};
            4'd4:    if (!w_empty) w_rdata = {24'h0, r_mem[r_rptr]};
            default: ;
         endcase
      end
   end

   assign bus.data_o   = w_rdata;
   assign bus.ready_o  = 1'b1;
   assign bus.m_req_o  = w_req;
   assign bus.m_we_o   = 1'b0;
   assign bus.m_addr_o = 32'h0002_0000;
   assign bus.m_data_o = '0;
   assign bus.irq_o    = r_irq;
endmodule
